// File: rtl/alu_op_pkg.sv
// Op-code and request-bit definitions shared by the ALU op encoder and decoder.
// Op codes are request index + 1, which encode_req relies on.
package alu_op_pkg;

   typedef logic [3:0] op_t;

   localparam op_t OP_NOP  = 4'd0;
   localparam op_t OP_NEG  = 4'd1;
   localparam op_t OP_INV  = 4'd2;
   localparam op_t OP_ANDL = 4'd3;
   localparam op_t OP_EQU  = 4'd4;
   localparam op_t OP_ORL  = 4'd5;
   localparam op_t OP_DEC  = 4'd6;
   localparam op_t OP_ADD  = 4'd7;
   localparam op_t OP_SUB  = 4'd8;
   localparam op_t OP_INC  = 4'd9;
   localparam op_t OP_CMP  = 4'd10;
   localparam op_t OP_MULS = 4'd11;

   localparam int REQ_NEG  = 0;
   localparam int REQ_INV  = 1;
   localparam int REQ_ANDL = 2;
   localparam int REQ_EQU  = 3;
   localparam int REQ_ORL  = 4;
   localparam int REQ_DEC  = 5;
   localparam int REQ_ADD  = 6;
   localparam int REQ_SUB  = 7;
   localparam int REQ_INC  = 8;
   localparam int REQ_CMP  = 9;
   localparam int REQ_MULS = 10;
   localparam int REQ_W    = 11;

   // Lowest set bit wins; an all-zero request maps to NOP.
   function automatic op_t encode_req(input logic [REQ_W-1:0] req);
      op_t code;
      code = OP_NOP;
      for (int i = REQ_W - 1; i >= 0; i--) begin
         if (req[i]) code = op_t'(i + 1);
      end
      return code;
   endfunction

   function automatic logic is_multi_hot(input logic [REQ_W-1:0] req);
      return (req & (req - REQ_W'(1))) != '0;
   endfunction

endpackage

// File: rtl/alu_op_fifo.sv
// DEPTH x W synchronous FIFO with combinational head read; push when full and
// pop when empty are ignored, simultaneous push/pop keeps occupancy.
module alu_op_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [W-1:0] mem [DEPTH];
   logic         do_push;
   logic         do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/alu_op_encoder.sv
// Encodes one-hot ALU requests, queues them and issues them with valid/ready,
// stalling for MUL_CYCLES after each MULS. ALU_OP_STATS_EN adds issue_count.
module alu_op_encoder
   import alu_op_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int MUL_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic [REQ_W-1:0] req,
   output logic             req_ready,
   output logic [3:0]       op,
   output logic             op_valid,
   input  logic             op_ready,
   output logic             busy,
   output logic             err_multi
`ifdef ALU_OP_STATS_EN
   ,
   output logic [15:0]      issue_count
`endif
);

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   typedef logic [CW-1:0] cnt_t;

   state_t state, state_nxt;
   cnt_t   cnt, cnt_nxt;
   op_t    op_nxt;
   logic   op_valid_nxt;
   logic   fifo_pop;
   logic   fifo_full;
   logic   fifo_empty;
   op_t    fifo_dout;
   logic   accept;

   assign req_ready = ~fifo_full;
   assign accept    = req_valid & req_ready;

   // Zero requests are accepted but never enqueued.
   alu_op_fifo #(.DEPTH(DEPTH), .W(4)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept && (req != '0)),
      .din   (encode_req(req)),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      op_nxt       = op;
      op_valid_nxt = op_valid;
      fifo_pop     = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop     = 1'b1;
               op_nxt       = fifo_dout;
               op_valid_nxt = 1'b1;
               state_nxt    = ISSUE;
            end
         end
         ISSUE: begin
            if (op_ready) begin
               if (op == OP_MULS) begin
                  op_valid_nxt = 1'b0;
                  cnt_nxt      = cnt_t'(MUL_CYCLES - 1);
                  state_nxt    = HOLD;
               end else if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  op_nxt   = fifo_dout;
               end else begin
                  op_valid_nxt = 1'b0;
                  state_nxt    = IDLE;
               end
            end
         end
         HOLD: begin
            op_valid_nxt = 1'b0;
            if (cnt == '0) state_nxt = IDLE;
            else           cnt_nxt   = cnt - cnt_t'(1);
         end
         default: begin
            op_valid_nxt = 1'b0;
            state_nxt    = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         op        <= OP_NOP;
         op_valid  <= 1'b0;
         err_multi <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         op       <= op_nxt;
         op_valid <= op_valid_nxt;
         if (accept && is_multi_hot(req)) err_multi <= 1'b1;
      end
   end

   assign busy = ~fifo_empty | op_valid | (state == HOLD);

`ifdef ALU_OP_STATS_EN
   always_ff @(posedge clk) begin
      if (rst)                        issue_count <= '0;
      else if (op_valid && op_ready)  issue_count <= issue_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_alu_op_encoder.sv
// Directed bench for alu_op_encoder with a queue scoreboard of expected op codes.
module tb_alu_op_encoder;
   import alu_op_pkg::*;

   localparam int DEPTH = 4;
   localparam int MUL   = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [10:0] req;
   logic        req_ready;
   logic [3:0]  op;
   logic        op_valid;
   logic        op_ready;
   logic        busy;
   logic        err_multi;
`ifdef ALU_OP_STATS_EN
   logic [15:0] issue_count;
`endif

   int checks = 0;
   int errors = 0;
   int hs_count = 0;
   logic [3:0] sb[$];

   alu_op_encoder #(.DEPTH(DEPTH), .MUL_CYCLES(MUL)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req       (req),
      .req_ready (req_ready),
      .op        (op),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .busy      (busy),
      .err_multi (err_multi)
`ifdef ALU_OP_STATS_EN
      ,
      .issue_count (issue_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] model_code(input logic [10:0] r);
      logic [3:0] c;
      logic       found;
      c = 4'd0;
      found = 1'b0;
      for (int i = 0; i < 11; i++) begin
         if (r[i] && !found) begin
            c = 4'(i + 1);
            found = 1'b1;
         end
      end
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 50) begin
         tick();
         n++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   // Scoreboard: push on request acceptance, pop/compare on op handshake.
   always @(posedge clk) begin
      if (rst) begin
         sb.delete();
         hs_count = 0;
      end else begin
         if (op_valid && op_ready) begin
            checks++;
            assert (sb.size() > 0) else begin
               errors++;
               $error("FAIL sb_underflow: observed op %0d with empty scoreboard", op);
            end
            if (sb.size() > 0) begin
               logic [3:0] exp_op;
               exp_op = sb.pop_front();
               checks++;
               assert (op === exp_op) else begin
                  errors++;
                  $error("FAIL sb_order: observed %0d expected %0d", op, exp_op);
               end
            end
            hs_count++;
         end
         if (req_valid && req_ready && req != 11'd0) sb.push_back(model_code(req));
      end
   end

   logic [10:0] bp_req[5];
   int k;
   int n;

   initial begin
      rst = 1'b1;
      req_valid = 1'b0;
      req = '0;
      op_ready = 1'b0;
      bp_req[0] = 11'h080; bp_req[1] = 11'h100; bp_req[2] = 11'h200;
      bp_req[3] = 11'h001; bp_req[4] = 11'h002;
      repeat (3) tick();
      chk("rst_op_valid", op_valid, 0);
      chk("rst_op", op, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_multi, 0);
      chk("rst_req_ready", req_ready, 1);
      rst = 1'b0;
      tick();

      // One-hot sweep: latency and code per request, MULS hold afterwards.
      op_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         req = 11'(1 << i);
         req_valid = 1'b1;
         chk("sweep_req_ready", req_ready, 1);
         tick();
         req_valid = 1'b0;
         req = '0;
         chk("sweep_lat_early", op_valid, 0);
         tick();
         chk("sweep_op_valid", op_valid, 1);
         chk("sweep_op", op, i + 1);
         tick();
         if (i == 10) begin
            for (int h = 0; h < MUL; h++) begin
               chk("sweep_hold_vld", op_valid, 0);
               chk("sweep_hold_busy", busy, 1);
               tick();
            end
         end
         wait_idle();
      end
`ifdef ALU_OP_STATS_EN
      chk("stats_sweep", issue_count, 11);
`endif

      // Backpressure: one op parked in the op register, then fill the FIFO.
      op_ready = 1'b0;
      req = 11'h040;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      chk("bp_head_vld", op_valid, 1);
      chk("bp_head_op", op, 7);
      for (int i = 0; i < 4; i++) begin
         req = bp_req[i];
         req_valid = 1'b1;
         chk("bp_accept_rdy", req_ready, 1);
         tick();
      end
      req = bp_req[4];
      for (int i = 0; i < 3; i++) begin
         chk("bp_full_rdy", req_ready, 0);
         chk("bp_op_stable", op, 7);
         chk("bp_vld_stable", op_valid, 1);
         tick();
      end
      op_ready = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         tick();
         n++;
      end
      chk("bp_reopen", req_ready, 1);
      tick();
      req_valid = 1'b0;
      req = '0;
      wait_idle();
      chk("bp_drained", sb.size(), 0);

      // Multi-hot request and zero request.
      req = 11'h006;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      req = '0;
      tick();
      chk("multi_op", op, 2);
      chk("multi_err", err_multi, 1);
      wait_idle();
      repeat (20) tick();
      chk("multi_err_sticky", err_multi, 1);
      req = 11'h000;
      req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("zero_busy", busy, 0);
         chk("zero_vld", op_valid, 0);
      end
      req_valid = 1'b0;

      // MULS followed by ADD: ADD must wait out the hold.
      req = 11'h400;
      req_valid = 1'b1;
      tick();
      req = 11'h040;
      tick();
      req_valid = 1'b0;
      req = '0;
      n = 0;
      while (!(op_valid && op == 4'd11) && n < 20) begin
         tick();
         n++;
      end
      chk("muls_issue", op, 11);
      tick();
      k = 0;
      while (!op_valid && k < 30) begin
         chk("muls_gap_busy", busy, 1);
         chk("muls_gap_op", op, 11);
         tick();
         k++;
      end
      chk("muls_gap_len", (k >= MUL), 1);
      chk("muls_add_vld", op_valid, 1);
      chk("muls_add_op", op, 7);
      wait_idle();

      // Reset during HOLD with ADD and SUB still queued.
      req_valid = 1'b1;
      req = 11'h400;
      tick();
      req = 11'h040;
      tick();
      req = 11'h080;
      tick();
      req_valid = 1'b0;
      req = '0;
      chk("hold_vld", op_valid, 0);
      chk("hold_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_vld", op_valid, 0);
      chk("abort_op", op, 0);
      chk("abort_busy", busy, 0);
      chk("abort_req_ready", req_ready, 1);
      chk("abort_err", err_multi, 0);
`ifdef ALU_OP_STATS_EN
      chk("stats_rst", issue_count, 0);
`endif
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("abort_no_residual", op_valid, 0);
      end
      chk("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
